block_uart_tx: RTL and testbench

BLOCK_UART_TX -- requirements
Module: block_uart_tx

---
 rtl/block_uart_tx.sv | 126 ++++++++++++
 tb/tb_block_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/block_uart_tx.sv
// block_uart_tx: serialises a multi-byte block over an 8N1/8N2 UART line,
// optionally appending an XOR checksum byte after the data bytes.
module block_uart_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int BLOCK_BYTES  = 16,
    parameter int MSB_FIRST    = 1,
    parameter int ADD_CHECKSUM = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [8*BLOCK_BYTES-1:0]            data_in,
    input  logic                                data_valid,
    output logic                                data_ready,
    output logic                                tx,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(BLOCK_BYTES+2)-1:0]    byte_count
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int NB       = BLOCK_BYTES + ADD_CHECKSUM;
    localparam int CW       = $clog2(BLOCK_BYTES + 2);
    localparam int BW       = $clog2(STOP_BITS * BAUD_DIV + 1);
    localparam int DW       = 8 * BLOCK_BYTES;
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
    localparam logic [CW-1:0] CSUM_IDX = CW'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   blk;
    logic [7:0]      cur;
    logic [7:0]      csum;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   baud_cnt;
    logic [7:0]      first_byte, blk_head, next_byte, csum_nx;
    logic [DW-1:0]   in_shift, blk_shift;
    logic            bit_end, stop_end;

    // blk holds the bytes still to send, always aligned so the next one sits at the head
    always_comb begin
        first_byte = MSB_FIRST != 0 ? data_in[DW-1 -: 8] : data_in[7:0];
        in_shift   = MSB_FIRST != 0 ? data_in << 8 : data_in >> 8;
        blk_head   = MSB_FIRST != 0 ? blk[DW-1 -: 8] : blk[7:0];
        blk_shift  = MSB_FIRST != 0 ? blk << 8 : blk >> 8;
        csum_nx    = csum ^ cur;
        next_byte  = (ADD_CHECKSUM != 0 && byte_count == CSUM_IDX) ? csum_nx : blk_head;
        bit_end    = baud_cnt == BW'(BAUD_DIV - 1);
        stop_end   = baud_cnt == BW'(STOP_BITS * BAUD_DIV - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
            bit_idx    <= '0;
            baud_cnt   <= '0;
            csum       <= '0;
            cur        <= '0;
            blk        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid && data_ready) begin
                        blk        <= in_shift;
                        cur        <= first_byte;
                        byte_count <= '0;
                        csum       <= '0;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        tx         <= 1'b0;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end else begin
                        data_ready <= 1'b1;
                    end
                end
                START: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    if (bit_end) begin
                        tx    <= cur[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= bit_idx == 3'd7 ? 1'b1 : cur[bit_idx + 3'd1];
                        state   <= bit_idx == 3'd7 ? STOP : DATA;
                    end
                end
                STOP: begin
                    baud_cnt <= stop_end ? '0 : baud_cnt + 1'b1;
                    if (stop_end) begin
                        byte_count <= byte_count + 1'b1;
                        csum       <= csum_nx;
                        if (byte_count == LAST_IDX) begin
                            tx    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= next_byte;
                            blk   <= blk_shift;
                            tx    <= 1'b0;
                            state <= START;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    data_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_uart_tx.sv
// tb_block_uart_tx: directed checks of block_uart_tx across several parameter sets,
// decoding the serial line and comparing against hand-computed bytes and timing.
module tb_block_uart_tx;
    localparam logic [127:0] PAT_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] PAT_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst_m, rst4;
    logic dv0, dv1, dv2, dv3, dv4, dv5;
    logic [127:0] d0, d1, d2, d4;
    logic [15:0]  d3;
    logic [7:0]   d5;
    wire  [5:0]   tx_v, rdy_v, busy_v, done_v;
    wire  [4:0]   bc0, bc1, bc2, bc4;
    wire  [1:0]   bc3, bc5;
    int n_cmp = 0;
    int n_err = 0;
    bit u0_fin = 1'b0;

    block_uart_tx u0 (.clk(clk), .reset(rst0), .data_in(d0), .data_valid(dv0), .data_ready(rdy_v[0]),
                      .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .byte_count(bc0));
    block_uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSB_FIRST(0)) u1 (
        .clk(clk), .reset(rst_m), .data_in(d1), .data_valid(dv1), .data_ready(rdy_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .byte_count(bc1));
    block_uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .ADD_CHECKSUM(1)) u2 (
        .clk(clk), .reset(rst_m), .data_in(d2), .data_valid(dv2), .data_ready(rdy_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .byte_count(bc2));
    block_uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .BLOCK_BYTES(2), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(rst_m), .data_in(d3), .data_valid(dv3), .data_ready(rdy_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]), .byte_count(bc3));
    block_uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) u4 (
        .clk(clk), .reset(rst4), .data_in(d4), .data_valid(dv4), .data_ready(rdy_v[4]),
        .tx(tx_v[4]), .busy(busy_v[4]), .done(done_v[4]), .byte_count(bc4));
    block_uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .BLOCK_BYTES(1)) u5 (
        .clk(clk), .reset(rst_m), .data_in(d5), .data_valid(dv5), .data_ready(rdy_v[5]),
        .tx(tx_v[5]), .busy(busy_v[5]), .done(done_v[5]), .byte_count(bc5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decodes one frame on line w; gap is negedges waited for the start bit
    // (0 when already low, 1 when frames are back to back).
    task automatic rx_check(input int w, input int div, input int sb, input logic [7:0] exp,
                            input bit first, input string tag);
        logic [7:0] b = '0;
        int lat = 0;
        bit bad = 1'b0;
        while (tx_v[w] !== 1'b0 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 1; c < (9 + sb) * div; c++) begin
            @(negedge clk);
            if (c < div && tx_v[w] !== 1'b0) bad = 1'b1;
            if (c >= 9 * div && tx_v[w] !== 1'b1) bad = 1'b1;
            if (c >= div && c < 9 * div && (c - div) % div == div / 2) b[(c - div) / div] = tx_v[w];
        end
        check({tag, " gap"}, 32'(lat), first ? 32'd0 : 32'd1);
        check({tag, " frame"}, 32'(bad), 32'd0);
        check({tag, " byte"}, 32'(b), 32'(exp));
    endtask

    task automatic pulse_wait;
        @(negedge clk);
    endtask

    // Default-parameter instance runs alongside the short-period tests.
    initial begin
        rst0 = 1'b0; dv0 = 1'b0; d0 = PAT_A;
        repeat (2) @(negedge clk);
        check("rst tx", 32'(tx_v[0]), 32'd1);
        check("rst ready", 32'(rdy_v[0]), 32'd0);
        check("rst busy", 32'(busy_v[0]), 32'd0);
        check("rst count", 32'(bc0), 32'd0);
        rst0 = 1'b1;
        @(negedge clk);
        check("def ready", 32'(rdy_v[0]), 32'd1);
        dv0 = 1'b1;
        @(negedge clk);
        dv0 = 1'b0;
        d0 = '0;
        for (int k = 0; k < 16; k++) rx_check(0, 434, 1, 8'(8'h11 * k), k == 0, "def");
        @(negedge clk);
        check("def done", 32'(done_v[0]), 32'd1);
        check("def count", 32'(bc0), 32'd16);
        check("def busy", 32'(busy_v[0]), 32'd1);
        @(negedge clk);
        check("def done end", 32'(done_v[0]), 32'd0);
        check("def ready end", 32'(rdy_v[0]), 32'd1);
        check("def idle tx", 32'(tx_v[0]), 32'd1);
        u0_fin = 1'b1;
    end

    initial begin
        bit seen;
        int guard;
        rst_m = 1'b0; rst4 = 1'b0;
        dv1 = 1'b0; dv2 = 1'b0; dv3 = 1'b0; dv4 = 1'b0; dv5 = 1'b0;
        d1 = PAT_A; d2 = 128'h01 << 120; d3 = 16'h3CC3; d4 = PAT_A; d5 = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst4 tx", 32'(tx_v[4]), 32'd1);
        check("rst4 ready", 32'(rdy_v[4]), 32'd0);
        rst_m = 1'b1; rst4 = 1'b1;
        @(negedge clk);
        check("first edge ready", 32'(rdy_v[1]), 32'd1);

        dv1 = 1'b1; pulse_wait(); dv1 = 1'b0;
        for (int k = 0; k < 16; k++) rx_check(1, 10, 1, 8'(8'hFF - 8'h11 * k), k == 0, "lsbf");
        @(negedge clk);
        check("lsbf done", 32'(done_v[1]), 32'd1);

        dv2 = 1'b1; pulse_wait(); dv2 = 1'b0;
        for (int k = 0; k < 17; k++) rx_check(2, 10, 1, (k == 0 || k == 16) ? 8'h01 : 8'h00, k == 0, "csum");
        @(negedge clk);
        check("csum done", 32'(done_v[2]), 32'd1);
        check("csum count", 32'(bc2), 32'd17);

        dv3 = 1'b1; pulse_wait(); dv3 = 1'b0;
        rx_check(3, 10, 2, 8'h3C, 1'b1, "stop2 b0");
        rx_check(3, 10, 2, 8'hC3, 1'b0, "stop2 b1");
        @(negedge clk);
        check("stop2 done", 32'(done_v[3]), 32'd1);

        dv5 = 1'b1; pulse_wait(); dv5 = 1'b0;
        rx_check(5, 10, 1, 8'hFF, 1'b1, "one ff");
        @(negedge clk);
        check("one done", 32'(done_v[5]), 32'd1);
        check("one count", 32'(bc5), 32'd1);
        @(negedge clk);
        check("one ready", 32'(rdy_v[5]), 32'd1);
        d5 = 8'h00;
        dv5 = 1'b1; pulse_wait(); dv5 = 1'b0;
        rx_check(5, 10, 1, 8'h00, 1'b1, "one 00");

        // data_valid held high with a new block through the whole transfer
        dv4 = 1'b1; pulse_wait();
        d4 = PAT_B;
        check("ign ready", 32'(rdy_v[4]), 32'd0);
        check("ign busy", 32'(busy_v[4]), 32'd1);
        for (int k = 0; k < 16; k++) begin
            rx_check(4, 10, 1, 8'(8'h11 * k), k == 0, "ign a");
            if (k == 7) check("ign ready mid", 32'(rdy_v[4]), 32'd0);
        end
        @(negedge clk);
        check("ign done", 32'(done_v[4]), 32'd1);
        @(negedge clk);
        check("ign ready idle", 32'(rdy_v[4]), 32'd1);
        @(negedge clk);
        dv4 = 1'b0;
        for (int k = 0; k < 16; k++) rx_check(4, 10, 1, 8'(8'h0F * (k + 1)), k == 0, "ign b");
        repeat (2) @(negedge clk);

        dv4 = 1'b1; pulse_wait(); dv4 = 1'b0;
        d4 = PAT_A;
        for (int k = 0; k < 5; k++) rx_check(4, 10, 1, 8'(8'h0F * (k + 1)), k == 0, "abort");
        repeat (46) @(negedge clk);
        check("abort busy pre", 32'(busy_v[4]), 32'd1);
        #2 rst4 = 1'b0;
        #1;
        check("abort tx", 32'(tx_v[4]), 32'd1);
        check("abort busy", 32'(busy_v[4]), 32'd0);
        check("abort ready", 32'(rdy_v[4]), 32'd0);
        check("abort count", 32'(bc4), 32'd0);
        seen = done_v[4];
        repeat (3) begin
            @(negedge clk);
            seen |= done_v[4];
        end
        rst4 = 1'b1;
        @(negedge clk);
        check("abort ready rel", 32'(rdy_v[4]), 32'd1);
        repeat (30) begin
            @(negedge clk);
            seen |= done_v[4] | ~tx_v[4];
        end
        check("abort quiet", 32'(seen), 32'd0);
        dv4 = 1'b1; pulse_wait(); dv4 = 1'b0;
        for (int k = 0; k < 16; k++) rx_check(4, 10, 1, 8'(8'h11 * k), k == 0, "resend");
        @(negedge clk);
        check("resend done", 32'(done_v[4]), 32'd1);
        check("resend count", 32'(bc4), 32'd16);

        guard = 0;
        while (!u0_fin && guard < 80000) begin
            @(negedge clk);
            guard++;
        end
        check("default run finished", 32'(u0_fin), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
